// File: rtl/tb_walker_if.sv
// Walker bus: start command, pointer-memory read port and op output stream.
// master = the traceback walker, slave = the host / memory side.
interface tb_walker_if #(
    parameter int REF_LEN_WIDTH   = 10,
    parameter int QUERY_LEN_WIDTH = 10,
    parameter int CNT_W           = 8
);
    logic                                     start;
    logic [REF_LEN_WIDTH-1:0]                 start_ref_idx;
    logic [QUERY_LEN_WIDTH-1:0]               start_query_idx;
    logic [1:0]                               start_state;
    logic                                     rd_en;
    logic [QUERY_LEN_WIDTH+REF_LEN_WIDTH-1:0] rd_addr;
    logic [3:0]                               rd_data;
    logic                                     op_valid;
    logic                                     op_ready;
    logic [1:0]                               op_code;
    logic [CNT_W-1:0]                         op_count;
    logic                                     busy;
    logic                                     done;
    logic                                     err;

    modport master (
        input  start, start_ref_idx, start_query_idx, start_state, rd_data, op_ready,
        output rd_en, rd_addr, op_valid, op_code, op_count, busy, done, err
    );

    modport slave (
        output start, start_ref_idx, start_query_idx, start_state, rd_data, op_ready,
        input  rd_en, rd_addr, op_valid, op_code, op_count, busy, done, err
    );
endinterface

// File: rtl/tb_walker.sv
// XDrop tile traceback walker: follows 4-bit direction pointers back to the tile origin
// and streams M/D/I ops. Define TB_RLE_EN to merge consecutive identical ops into runs.
module tb_walker #(
    parameter int REF_LEN_WIDTH   = 10,
    parameter int QUERY_LEN_WIDTH = 10,
    parameter int RD_LAT          = 1,
    parameter int CNT_W           = 8
) (
    input logic         clk,
    input logic         rst,
    tb_walker_if.master bus
);
    localparam int AW = QUERY_LEN_WIDTH + REF_LEN_WIDTH;
    localparam logic [1:0] OP_M = 2'd0;
    localparam logic [1:0] OP_D = 2'd1;
    localparam logic [1:0] OP_I = 2'd2;
    localparam logic [1:0] MS_H = 2'd0;
    localparam logic [1:0] MS_D = 2'd1;
    localparam logic [1:0] MS_I = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE, ST_CHECK, ST_REQ, ST_WAIT, ST_EMIT, ST_OUT, ST_FLUSH, ST_FIN
    } state_e;

    // Returns {illegal, op, next_mstate} for one pointer word seen from matrix ms.
    function automatic logic [4:0] decode_dir(input logic [1:0] ms, input logic [3:0] dir);
        logic [4:0] res;
        res = {1'b1, OP_M, MS_H};
        case (ms)
            MS_H: begin
                case (dir[1:0])
                    2'b00:   res = {1'b0, OP_M, MS_H};
                    2'b01:   res = {1'b0, OP_D, (dir[2] ? MS_D : MS_H)};
                    2'b10:   res = {1'b0, OP_I, (dir[3] ? MS_I : MS_H)};
                    default: res = {1'b1, OP_M, MS_H};
                endcase
            end
            MS_D:    res = {1'b0, OP_D, (dir[2] ? MS_D : MS_H)};
            MS_I:    res = {1'b0, OP_I, (dir[3] ? MS_I : MS_H)};
            default: res = {1'b1, OP_M, MS_H};
        endcase
        return res;
    endfunction

    state_e                     state_q, state_d;
    logic [REF_LEN_WIDTH-1:0]   ref_q, ref_d;
    logic [QUERY_LEN_WIDTH-1:0] qry_q, qry_d;
    logic [1:0]                 mstate_q, mstate_d;
    logic [1:0]                 cur_op_q, cur_op_d;
    logic [1:0]                 cur_ms_q, cur_ms_d;
    logic [1:0]                 wcnt_q, wcnt_d;
    logic [1:0]                 run_code_q, run_code_d;
    logic [CNT_W-1:0]           run_cnt_q, run_cnt_d;
    logic                       rd_en_q, rd_en_d;
    logic [AW-1:0]              rd_addr_q, rd_addr_d;
    logic                       op_valid_q, op_valid_d;
    logic [1:0]                 op_code_q, op_code_d;
    logic [CNT_W-1:0]           op_count_q, op_count_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       err_q, err_d;

    logic [4:0]                 dec_s;
    logic [REF_LEN_WIDTH-1:0]   ref_dec_s;
    logic [QUERY_LEN_WIDTH-1:0] qry_dec_s;

    assign dec_s     = decode_dir(mstate_q, bus.rd_data);
    assign ref_dec_s = (ref_q != '0) ? ref_q - REF_LEN_WIDTH'(1) : ref_q;
    assign qry_dec_s = (qry_q != '0) ? qry_q - QUERY_LEN_WIDTH'(1) : qry_q;

    // Next-state logic; indices move only when the pending op (cur_op) is committed.
    always_comb begin
        state_d    = state_q;
        ref_d      = ref_q;
        qry_d      = qry_q;
        mstate_d   = mstate_q;
        cur_op_d   = cur_op_q;
        cur_ms_d   = cur_ms_q;
        wcnt_d     = wcnt_q;
        run_code_d = run_code_q;
        run_cnt_d  = run_cnt_q;
        rd_en_d    = 1'b0;
        rd_addr_d  = rd_addr_q;
        op_valid_d = op_valid_q;
        op_code_d  = op_code_q;
        op_count_d = op_count_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    ref_d     = bus.start_ref_idx;
                    qry_d     = bus.start_query_idx;
                    mstate_d  = bus.start_state;
                    run_cnt_d = '0;
                    if (bus.start_state == 2'd3) begin
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_FIN;
                    end else begin
                        err_d   = 1'b0;
                        busy_d  = 1'b1;
                        state_d = ST_CHECK;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (ref_q == '0 && qry_q == '0) begin
                    state_d = ST_FLUSH;
                end else if (ref_q == '0 || qry_q == '0) begin
                    // On a tile edge the only legal move is along that edge.
                    cur_op_d = (ref_q == '0) ? OP_I : OP_D;
                    cur_ms_d = (ref_q == '0) ? MS_I : MS_D;
                    state_d  = ST_EMIT;
`ifndef TB_RLE_EN
                    op_valid_d = 1'b1;
                    op_code_d  = cur_op_d;
                    op_count_d = CNT_W'(1);
`endif
                end else begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = {qry_q, ref_q};
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                wcnt_d  = 2'd0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (wcnt_q == 2'(RD_LAT - 1)) begin
                    if (dec_s[4]) begin
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_FIN;
                    end else begin
                        cur_op_d = dec_s[3:2];
                        cur_ms_d = dec_s[1:0];
                        state_d  = ST_EMIT;
`ifndef TB_RLE_EN
                        op_valid_d = 1'b1;
                        op_code_d  = dec_s[3:2];
                        op_count_d = CNT_W'(1);
`endif
                    end
                end else begin
                    wcnt_d = wcnt_q + 2'd1;
                end
            end
`ifdef TB_RLE_EN
            ST_EMIT: begin
                if (run_cnt_q == '0 || (run_code_q == cur_op_q && run_cnt_q != '1)) begin
                    run_code_d = cur_op_q;
                    run_cnt_d  = run_cnt_q + CNT_W'(1);
                    ref_d      = (cur_op_q == OP_I) ? ref_q : ref_dec_s;
                    qry_d      = (cur_op_q == OP_D) ? qry_q : qry_dec_s;
                    mstate_d   = cur_ms_q;
                    state_d    = ST_CHECK;
                end else begin
                    op_valid_d = 1'b1;
                    op_code_d  = run_code_q;
                    op_count_d = run_cnt_q;
                    state_d    = ST_OUT;
                end
            end
            ST_OUT: begin
                // run_cnt_q==0 here means the run was handed out by FLUSH.
                if (bus.op_ready) begin
                    op_valid_d = 1'b0;
                    if (run_cnt_q == '0) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_FIN;
                    end else begin
                        run_code_d = cur_op_q;
                        run_cnt_d  = CNT_W'(1);
                        ref_d      = (cur_op_q == OP_I) ? ref_q : ref_dec_s;
                        qry_d      = (cur_op_q == OP_D) ? qry_q : qry_dec_s;
                        mstate_d   = cur_ms_q;
                        state_d    = ST_CHECK;
                    end
                end else begin
                    state_d = ST_OUT;
                end
            end
            ST_FLUSH: begin
                if (run_cnt_q != '0) begin
                    op_valid_d = 1'b1;
                    op_code_d  = run_code_q;
                    op_count_d = run_cnt_q;
                    run_cnt_d  = '0;
                    state_d    = ST_OUT;
                end else begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_FIN;
                end
            end
`else
            ST_EMIT: begin
                if (bus.op_ready) begin
                    op_valid_d = 1'b0;
                    ref_d      = (cur_op_q == OP_I) ? ref_q : ref_dec_s;
                    qry_d      = (cur_op_q == OP_D) ? qry_q : qry_dec_s;
                    mstate_d   = cur_ms_q;
                    state_d    = ST_CHECK;
                end else begin
                    state_d = ST_EMIT;
                end
            end
            ST_FLUSH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_FIN;
            end
`endif
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                op_valid_d = 1'b0;
                busy_d     = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; rst aborts a walk at once without a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ref_q      <= '0;
            qry_q      <= '0;
            mstate_q   <= MS_H;
            cur_op_q   <= OP_M;
            cur_ms_q   <= MS_H;
            wcnt_q     <= 2'd0;
            run_code_q <= OP_M;
            run_cnt_q  <= '0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            op_valid_q <= 1'b0;
            op_code_q  <= 2'd0;
            op_count_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ref_q      <= ref_d;
            qry_q      <= qry_d;
            mstate_q   <= mstate_d;
            cur_op_q   <= cur_op_d;
            cur_ms_q   <= cur_ms_d;
            wcnt_q     <= wcnt_d;
            run_code_q <= run_code_d;
            run_cnt_q  <= run_cnt_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            op_valid_q <= op_valid_d;
            op_code_q  <= op_code_d;
            op_count_q <= op_count_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.rd_en    = rd_en_q;
    assign bus.rd_addr  = rd_addr_q;
    assign bus.op_valid = op_valid_q;
    assign bus.op_code  = op_code_q;
    assign bus.op_count = op_count_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_tb_walker.sv
// Directed bench for tb_walker with a 1-cycle pointer memory model; expected op
// streams switch to run-length form when TB_RLE_EN is defined.
module tb_tb_walker;
    localparam int RW = 10;
    localparam int QW = 10;
    localparam int RL = 1;
    localparam int CW = 8;
    localparam logic [1:0] OP_M = 2'd0;
    localparam logic [1:0] OP_D = 2'd1;
    localparam logic [1:0] OP_I = 2'd2;
`ifdef TB_RLE_EN
    localparam int HOLD_CNT = 3;
`else
    localparam int HOLD_CNT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    logic [3:0]  mem [0:63];
    logic [9:0]  ops [$];
    int          op_t [$];
    logic [19:0] rds [$];
    logic [9:0]  exp_ops [$];
    logic [19:0] exp_rds [$];

    tb_walker_if #(.REF_LEN_WIDTH(RW), .QUERY_LEN_WIDTH(QW), .CNT_W(CW)) bus ();

    tb_walker #(.REF_LEN_WIDTH(RW), .QUERY_LEN_WIDTH(QW), .RD_LAT(RL), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) bus.rd_data <= 4'd0;
        else if (bus.rd_en) bus.rd_data <= mem[{bus.rd_addr[QW+2:QW], bus.rd_addr[2:0]}];
    end

    always @(negedge clk) begin
        if (bus.op_valid && bus.op_ready) begin
            ops.push_back({bus.op_code, bus.op_count});
            op_t.push_back(cyc);
        end
        if (bus.rd_en) rds.push_back(bus.rd_addr);
        if (bus.done) done_cnt++;
    end

    function automatic logic [9:0] op(input logic [1:0] code, input int cnt);
        return {code, CW'(cnt)};
    endfunction

    function automatic logic [19:0] ad(input int r, input int q);
        return {QW'(q), RW'(r)};
    endfunction

    function automatic int key(input int r, input int q);
        return (q % 8) * 8 + (r % 8);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic go(input int r, input int q, input int st);
        bus.start_ref_idx   = RW'(r);
        bus.start_query_idx = QW'(q);
        bus.start_state     = 2'(st);
        bus.start           = 1'b1;
        tick(1);
        bus.start           = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, output int lat);
        int n;
        n = 0;
        while (!bus.done && n < budget) begin
            tick(1);
            n++;
        end
        lat = n;
        chk({tag, "_done_seen"}, 32'(bus.done), 32'd1);
    endtask

    task automatic chk_walk(input string tag, input int ob, input int rb);
        chk({tag, "_nops"}, 32'(ops.size() - ob), 32'(exp_ops.size()));
        foreach (exp_ops[i])
            chk($sformatf("%s_op%0d", tag, i),
                32'((ob + i < ops.size()) ? ops[ob + i] : 10'h3ff), 32'(exp_ops[i]));
        chk({tag, "_nrds"}, 32'(rds.size() - rb), 32'(exp_rds.size()));
        foreach (exp_rds[i])
            chk($sformatf("%s_rd%0d", tag, i),
                32'((rb + i < rds.size()) ? rds[rb + i] : 20'hfffff), 32'(exp_rds[i]));
    endtask

    task automatic clr_mem();
        foreach (mem[i]) mem[i] = 4'd0;
    endtask

    initial begin
        int ob, rb, dc, tb, lat, n;
        rst                 = 1'b1;
        bus.start           = 1'b0;
        bus.start_ref_idx   = '0;
        bus.start_query_idx = '0;
        bus.start_state     = 2'd0;
        bus.op_ready        = 1'b1;
        clr_mem();
        tick(2);
        chk("rst_rd_en",    32'(bus.rd_en),    32'd0);
        chk("rst_rd_addr",  32'(bus.rd_addr),  32'd0);
        chk("rst_op_valid", 32'(bus.op_valid), 32'd0);
        chk("rst_op_code",  32'(bus.op_code),  32'd0);
        chk("rst_op_count", 32'(bus.op_count), 32'd0);
        chk("rst_busy",     32'(bus.busy),     32'd0);
        chk("rst_done",     32'(bus.done),     32'd0);
        chk("rst_err",      32'(bus.err),      32'd0);
        rst = 1'b0;
        tick(1);

        // Diagonal walk from (3,3); a second start mid-walk must be ignored.
        ob = ops.size(); rb = rds.size(); dc = done_cnt; tb = op_t.size();
        go(3, 3, 0);
        chk("w1_busy", 32'(bus.busy), 32'd1);
        tick(2);
        bus.start_ref_idx = 10'd1; bus.start_query_idx = 10'd0; bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        wait_done("w1", 100, lat);
        tick(2);
        exp_ops.delete(); exp_rds.delete();
`ifdef TB_RLE_EN
        exp_ops.push_back(op(OP_M, 3));
`else
        repeat (3) exp_ops.push_back(op(OP_M, 1));
`endif
        exp_rds.push_back(ad(3, 3)); exp_rds.push_back(ad(2, 2)); exp_rds.push_back(ad(1, 1));
        chk_walk("w1", ob, rb);
        chk("w1_dones", 32'(done_cnt - dc), 32'd1);
        chk("w1_busy_end", 32'(bus.busy), 32'd0);
`ifndef TB_RLE_EN
        chk("w1_period", 32'((op_t.size() > tb + 1) ? op_t[tb+1] - op_t[tb] : 0), 32'(RL + 3));
`endif

        // Horizontal run through the D matrix, then diagonal.
        mem[key(4, 2)] = 4'b0101;
        mem[key(3, 2)] = 4'b0001;
        ob = ops.size(); rb = rds.size();
        go(4, 2, 0);
        wait_done("w2", 100, lat);
        tick(2);
        exp_ops.delete(); exp_rds.delete();
`ifdef TB_RLE_EN
        exp_ops.push_back(op(OP_D, 2)); exp_ops.push_back(op(OP_M, 2));
`else
        exp_ops.push_back(op(OP_D, 1)); exp_ops.push_back(op(OP_D, 1));
        exp_ops.push_back(op(OP_M, 1)); exp_ops.push_back(op(OP_M, 1));
`endif
        exp_rds.push_back(ad(4, 2)); exp_rds.push_back(ad(3, 2));
        exp_rds.push_back(ad(2, 2)); exp_rds.push_back(ad(1, 1));
        chk_walk("w2", ob, rb);
        clr_mem();

        // Vertical run through the I matrix, then diagonal.
        mem[key(1, 3)] = 4'b1010;
        mem[key(1, 2)] = 4'b0010;
        ob = ops.size(); rb = rds.size();
        go(1, 3, 0);
        wait_done("w3", 100, lat);
        tick(2);
        exp_ops.delete(); exp_rds.delete();
`ifdef TB_RLE_EN
        exp_ops.push_back(op(OP_I, 2)); exp_ops.push_back(op(OP_M, 1));
`else
        exp_ops.push_back(op(OP_I, 1)); exp_ops.push_back(op(OP_I, 1));
        exp_ops.push_back(op(OP_M, 1));
`endif
        exp_rds.push_back(ad(1, 3)); exp_rds.push_back(ad(1, 2)); exp_rds.push_back(ad(1, 1));
        chk_walk("w3", ob, rb);
        clr_mem();

        // Edge of tile: ops synthesized without reads.
        ob = ops.size(); rb = rds.size(); tb = op_t.size();
        go(2, 0, 0);
        wait_done("w4", 100, lat);
        tick(2);
        exp_ops.delete(); exp_rds.delete();
`ifdef TB_RLE_EN
        exp_ops.push_back(op(OP_D, 2));
`else
        exp_ops.push_back(op(OP_D, 1)); exp_ops.push_back(op(OP_D, 1));
        chk("w4_period", 32'((op_t.size() > tb + 1) ? op_t[tb+1] - op_t[tb] : 0), 32'd2);
`endif
        chk_walk("w4", ob, rb);

        // Origin start: nothing to emit, done two cycles after start.
        ob = ops.size(); rb = rds.size();
        go(0, 0, 0);
        wait_done("w5", 20, lat);
        chk("w5_latency", 32'(lat), 32'd2);
        tick(2);
        exp_ops.delete(); exp_rds.delete();
        chk_walk("w5", ob, rb);

        // Illegal pointer in H, then illegal start state, then err cleared.
        mem[key(3, 3)] = 4'b0011;
        ob = ops.size(); rb = rds.size(); dc = done_cnt;
        go(3, 3, 0);
        wait_done("e1", 100, lat);
        tick(2);
        chk("e1_err", 32'(bus.err), 32'd1);
        chk("e1_dones", 32'(done_cnt - dc), 32'd1);
        exp_ops.delete(); exp_rds.delete();
        exp_rds.push_back(ad(3, 3));
        chk_walk("e1", ob, rb);
        clr_mem();
        ob = ops.size(); rb = rds.size();
        go(3, 3, 3);
        wait_done("e2", 20, lat);
        tick(2);
        chk("e2_err", 32'(bus.err), 32'd1);
        exp_rds.delete();
        chk_walk("e2", ob, rb);
        go(0, 0, 0);
        chk("e3_err_clr", 32'(bus.err), 32'd0);
        wait_done("e3", 20, lat);
        tick(2);

        // Backpressure: op held stable while op_ready is low.
        ob = ops.size(); rb = rds.size();
        bus.op_ready = 1'b0;
        go(3, 3, 0);
        n = 0;
        while (!bus.op_valid && n < 50) begin tick(1); n++; end
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("h_valid%0d", k), 32'(bus.op_valid), 32'd1);
            chk($sformatf("h_code%0d", k),  32'(bus.op_code),  32'(OP_M));
            chk($sformatf("h_count%0d", k), 32'(bus.op_count), 32'(HOLD_CNT));
            tick(1);
        end
        bus.op_ready = 1'b1;
        wait_done("h", 100, lat);
        tick(2);
        exp_ops.delete(); exp_rds.delete();
`ifdef TB_RLE_EN
        exp_ops.push_back(op(OP_M, 3));
`else
        repeat (3) exp_ops.push_back(op(OP_M, 1));
`endif
        exp_rds.push_back(ad(3, 3)); exp_rds.push_back(ad(2, 2)); exp_rds.push_back(ad(1, 1));
        chk_walk("h", ob, rb);

        // Asynchronous reset mid-walk clears outputs with no done pulse.
        bus.op_ready = 1'b0;
        go(3, 3, 0);
        n = 0;
        while (!bus.op_valid && n < 50) begin tick(1); n++; end
        chk("r_valid_pre", 32'(bus.op_valid), 32'd1);
        dc = done_cnt;
        rst = 1'b1;
        #1;
        chk("r_rd_en",    32'(bus.rd_en),    32'd0);
        chk("r_rd_addr",  32'(bus.rd_addr),  32'd0);
        chk("r_op_valid", 32'(bus.op_valid), 32'd0);
        chk("r_op_count", 32'(bus.op_count), 32'd0);
        chk("r_busy",     32'(bus.busy),     32'd0);
        chk("r_done",     32'(bus.done),     32'd0);
        tick(2);
        rst = 1'b0;
        bus.op_ready = 1'b1;
        tick(5);
        chk("r_no_done", 32'(done_cnt - dc), 32'd0);
        chk("r_idle", 32'(bus.busy), 32'd0);

        // Walker recovers after the abort.
        ob = ops.size(); rb = rds.size();
        go(1, 1, 0);
        wait_done("r2", 100, lat);
        tick(2);
        exp_ops.delete(); exp_rds.delete();
        exp_ops.push_back(op(OP_M, 1));
        exp_rds.push_back(ad(1, 1));
        chk_walk("r2", ob, rb);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tb_walker.md
Name: tb_walker

Overview:
- Traceback engine for one tile of the XDrop systolic array.
- Walks backward through the 4-bit direction pointers that the PE array writes into tile pointer memory.
- Emits the alignment as a stream of ops (match/mismatch, deletion, insertion) from the start cell back to the tile origin.
- Sits between the pointer memory read port and the host-side alignment/CIGAR writer.

Parameters:
- REF_LEN_WIDTH, 10, width of reference cell index.
- QUERY_LEN_WIDTH, 10, width of query cell index.
- RD_LAT, 1, pointer memory read latency in cycles (1..4).
- CNT_W, 8, width of op run-length count.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse; begin traceback (accepted only in IDLE)
- start_ref_idx  in  REF_LEN_WIDTH  reference index of start cell
- start_query_idx  in  QUERY_LEN_WIDTH  query index of start cell
- start_state  in  2  initial matrix: 0=H, 1=D, 2=I (3 illegal)
- rd_en  out  1  pointer memory read strobe
- rd_addr  out  QUERY_LEN_WIDTH+REF_LEN_WIDTH  {query_idx, ref_idx}
- rd_data  in  4  dir word, valid RD_LAT cycles after rd_en
- op_valid  out  1  op output valid
- op_ready  in  1  downstream ready
- op_code  out  2  0=M (diag), 1=D (horizontal, ref consumed), 2=I (vertical, query consumed)
- op_count  out  CNT_W  run length of op_code
- busy  out  1  walker active
- done  out  1  one-cycle pulse at completion
- err  out  1  sticky error, cleared by next accepted start

Behaviour:
- Reset: state IDLE; rd_en=0, rd_addr=0, op_valid=0, op_code=0, op_count=0, busy=0, done=0, err=0. Asserting rst mid-walk aborts immediately with no done pulse.
- States: IDLE -> CHECK -> REQ -> WAIT -> EMIT -> CHECK ... -> FLUSH -> FIN -> IDLE.
- IDLE: start latches indices and matrix state (mstate), clears err, busy=1. start with start_state=3: err=1, go FIN.
- start while busy: ignored, no effect.
- CHECK: both indices 0 -> FLUSH.
- CHECK, ref_idx=0, query_idx>0: synthesize op I with no memory read; query_idx--; mstate=I.
- CHECK, query_idx=0, ref_idx>0: synthesize op D with no memory read; ref_idx--; mstate=D.
- CHECK, otherwise: go REQ.
- REQ: rd_en=1 for exactly one cycle, rd_addr={query_idx,ref_idx}. WAIT counts RD_LAT cycles, then captures rd_data into dir.
- Pointer decode, mstate=H:
  - dir[1:0]=00 -> op M; ref--, query--; mstate=H.
  - dir[1:0]=01 -> op D; ref--; mstate = dir[2] ? D : H.
  - dir[1:0]=10 -> op I; query--; mstate = dir[3] ? I : H.
  - dir[1:0]=11 -> err=1, go FIN.
- Pointer decode, mstate=D: op D; ref--; mstate = dir[2] ? D : H.
- Pointer decode, mstate=I: op I; query--; mstate = dir[3] ? I : H.
- EMIT: op_valid=1. Hold op_code and op_count stable until op_ready. Index and state update occur on the handshake cycle, then go CHECK.
- Throughput: one op per RD_LAT+3 cycles with op_ready held high; boundary-synthesized ops take 2 cycles.
- Arithmetic: indices never decrement below 0.
- FLUSH: emit any pending run (RLE build only), then FIN.
- FIN: done=1 for one cycle, busy=0, return to IDLE.

Optional Feature:
- Macro TB_RLE_EN.
- Defined:
  - Consecutive identical ops merge into one output with op_count = run length.
  - A run is emitted when the op changes, at FLUSH, or when count reaches 2^CNT_W-1; the saturated run is emitted and a new run starts at 1.
  - The merge step takes no memory read.
- Undefined: every op is emitted individually with op_count=1; FLUSH passes straight through.

Test Plan:
- Start (3,3), state H, all dir=0000, op_ready=1 -> ops M,M,M (count 1 each), reads at {3,3},{2,2},{1,1}, then done; with TB_RLE_EN: single op M, count 3.
- Start (4,2), state H; dir(4,2)=0101, dir(3,2)=0001, dir(2,2)=0000, dir(1,1)=0000 -> D,D,M,M.
- Start (1,3), state H; dir(1,3)=1010, dir(1,2)=0010, dir(1,1)=0000 -> I,I,M, done.
- Start (2,0), state H -> D,D synthesized, rd_en never asserted. Start (0,0) -> no ops, done 2 cycles after start.
- Start (3,3), state H; dir=0011 -> err=1, done pulse, no ops; next start with start_state=3 -> err=1, done, no reads.
- op_ready low for 5 cycles during EMIT -> op_valid held, op_code and op_count stable. rst asserted mid-walk -> all outputs 0 asynchronously, no done pulse; start during busy ignored.
